// File: rtl/nabp_filtered_ram_swap_control.sv
// nabp_filtered_ram_swap_control: ping-pong filtered-projection banks with angle grant and two registered read ports
module nabp_filtered_ram_swap_control #(
    parameter int DATA_WIDTH  = 12,
    parameter int S_WIDTH     = 9,
    parameter int ANGLE_WIDTH = 8,
    parameter int NO_OF_S     = 256
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_hs_valid,
    output logic                          o_hs_ready,
    input  logic signed [DATA_WIDTH-1:0]  i_hs_data,
    input  logic        [ANGLE_WIDTH-1:0] i_hs_angle,
    input  logic                          i_hs_last_angle,
    input  logic                          i_fr_next_angle,
    output logic                          o_fr_next_angle_ack,
    output logic        [ANGLE_WIDTH-1:0] o_fr_angle,
    output logic                          o_fr_has_next_angle,
    input  logic signed [S_WIDTH-1:0]     i_fr0_s_val,
    input  logic signed [S_WIDTH-1:0]     i_fr1_s_val,
    output logic signed [DATA_WIDTH-1:0]  o_fr0_val,
    output logic signed [DATA_WIDTH-1:0]  o_fr1_val
);
    localparam int IW = $clog2(NO_OF_S);
    localparam logic [S_WIDTH-1:0] L_NS = S_WIDTH'(NO_OF_S);
    localparam logic [IW-1:0] L_LAST = IW'(NO_OF_S - 1);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
    bank_state_t                  r_state [2];
    logic signed [DATA_WIDTH-1:0] r_mem [2][NO_OF_S];
    logic [ANGLE_WIDTH-1:0]       r_angle [2];
    logic [1:0]                   r_last;
    logic                         r_wr_bank, r_rd_bank, r_rd_valid;
    logic [IW-1:0]                r_wr_idx;
    logic                         w_wr, w_gnt_bank, w_in0, w_in1;
    assign o_hs_ready = !i_reset && (r_state[r_wr_bank] == EMPTY || r_state[r_wr_bank] == FILLING);
    assign w_wr = i_hs_valid && o_hs_ready;
    // Before the first grant the candidate is bank 0; afterwards always the bank not being read.
    assign w_gnt_bank = r_rd_bank ^ r_rd_valid;
    assign o_fr_next_angle_ack = !i_reset && i_fr_next_angle && o_fr_has_next_angle && r_state[w_gnt_bank] == FULL;
    // A negative index reinterpreted as unsigned is >= 2^(S_WIDTH-1) >= NO_OF_S, so one compare covers both bounds.
    assign w_in0 = r_rd_valid && ($unsigned(i_fr0_s_val) < L_NS);
    assign w_in1 = r_rd_valid && ($unsigned(i_fr1_s_val) < L_NS);
    always_ff @(posedge i_clk)
        if (w_wr) r_mem[r_wr_bank][r_wr_idx] <= i_hs_data;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state[0]          <= EMPTY;
            r_state[1]          <= EMPTY;
            r_angle[0]          <= '0;
            r_angle[1]          <= '0;
            r_last              <= '0;
            r_wr_bank           <= 1'b0;
            r_wr_idx            <= '0;
            r_rd_bank           <= 1'b0;
            r_rd_valid          <= 1'b0;
            o_fr_angle          <= '0;
            o_fr_has_next_angle <= 1'b1;
            o_fr0_val           <= '0;
            o_fr1_val           <= '0;
        end else begin
            if (w_wr) begin
                if (r_wr_idx == '0) begin
                    r_state[r_wr_bank]  <= FILLING;
                    r_angle[r_wr_bank]  <= i_hs_angle;
                    r_last[r_wr_bank]   <= i_hs_last_angle;
                    o_fr_has_next_angle <= 1'b1;
                end
                if (r_wr_idx == L_LAST) begin
                    r_state[r_wr_bank] <= FULL;
                    r_wr_idx           <= '0;
                    r_wr_bank          <= !r_wr_bank;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            // The write bank is never the granted or the released bank, so both updates coexist.
            if (o_fr_next_angle_ack) begin
                r_state[w_gnt_bank] <= READING;
                if (r_rd_valid) r_state[r_rd_bank] <= EMPTY;
                r_rd_bank  <= w_gnt_bank;
                r_rd_valid <= 1'b1;
                o_fr_angle <= r_angle[w_gnt_bank];
                if (r_last[w_gnt_bank]) o_fr_has_next_angle <= 1'b0;
            end
            o_fr0_val <= w_in0 ? r_mem[r_rd_bank][i_fr0_s_val[IW-1:0]] : '0;
            o_fr1_val <= w_in1 ? r_mem[r_rd_bank][i_fr1_s_val[IW-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// tb_nabp_filtered_ram_swap_control: directed checks of fill, grant, read, frame restart and async reset
module tb_nabp_filtered_ram_swap_control;
    logic              clk = 1'b0;
    logic              rst;
    logic              hs_valid, hs_ready, hs_last;
    logic signed [11:0] hs_data;
    logic [7:0]        hs_angle;
    logic              next_angle, ack, has_next;
    logic [7:0]        fr_angle;
    logic signed [8:0] s0, s1;
    logic signed [11:0] v0, v1;
    logic              ready_last, ack_last;
    int                n_chk = 0;
    int                n_pass = 0;

    nabp_filtered_ram_swap_control dut (
        .i_clk(clk), .i_reset(rst),
        .i_hs_valid(hs_valid), .o_hs_ready(hs_ready), .i_hs_data(hs_data),
        .i_hs_angle(hs_angle), .i_hs_last_angle(hs_last),
        .i_fr_next_angle(next_angle), .o_fr_next_angle_ack(ack),
        .o_fr_angle(fr_angle), .o_fr_has_next_angle(has_next),
        .i_fr0_s_val(s0), .i_fr1_s_val(s1), .o_fr0_val(v0), .o_fr1_val(v1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Presents n samples base+step*i, one per cycle; returns at the negedge after the last handshake.
    task automatic write_line(input int ang, input int last, input int base, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            hs_valid = 1'b1;
            hs_data  = 12'(base + step * i);
            hs_angle = 8'(ang);
            hs_last  = last[0];
            #1;
            ready_last = hs_ready;
            ack_last   = ack;
            @(negedge clk);
        end
        hs_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hs_valid = 1'b0; hs_data = '0; hs_angle = '0; hs_last = 1'b0;
        next_angle = 1'b1; s0 = 9'sd5; s1 = 9'sd200;
        @(negedge clk); #1;
        chk("rst_ready", hs_ready, 0);
        chk("rst_ack", ack, 0);
        chk("rst_has_next", has_next, 1);
        chk("rst_angle", fr_angle, 0);
        chk("rst_v0", v0, 0);
        next_angle = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", hs_ready, 1);
        // first line, angle 10, data = i
        write_line(10, 0, 0, 1, 256);
        chk("pre_grant_v0", v0, 0);
        chk("ready_other_bank", hs_ready, 1);
        next_angle = 1'b1;
        #1 chk("ack_first", ack, 1);
        @(negedge clk);
        next_angle = 1'b0;
        chk("angle_10", fr_angle, 10);
        chk("ack_cycle_read", v0, 0);
        @(negedge clk);
        chk("read_s5", v0, 5);
        chk("read_s200", v1, 200);
        // second line, angle 20, data = -i, filled while angle 10 is read
        write_line(20, 0, 0, -1, 256);
        chk("ready_at_255", ready_last, 1);
        chk("ready_both_busy", hs_ready, 0);
        chk("persist_angle10", v0, 5);
        next_angle = 1'b1;
        #1 chk("ack_second", ack, 1);
        @(negedge clk);
        next_angle = 1'b0;
        chk("freed_writable", hs_ready, 1);
        chk("angle_20", fr_angle, 20);
        chk("ack_old_bank", v0, 5);
        @(negedge clk);
        chk("new_bank_s5", v0, -5);
        chk("new_bank_s200", v1, -200);
        s0 = -9'sd1; s1 = -9'sd256;
        @(negedge clk);
        chk("read_neg1", v0, 0);
        chk("read_s256", v1, 0);
        s0 = 9'sd100; s1 = 9'sd100;
        @(negedge clk);
        chk("same_idx_p0", v0, -100);
        chk("same_idx_p1", v1, -100);
        // held request with no full bank; last-angle line completes later
        next_angle = 1'b1;
        #1 chk("no_full_no_ack", ack, 0);
        write_line(30, 1, 500, 1, 256);
        chk("ack_line_done_cycle", ack_last, 0);
        #1 chk("ack_next_cycle", ack, 1);
        @(negedge clk);
        chk("has_next_cleared", has_next, 0);
        chk("angle_30", fr_angle, 30);
        #1 chk("no_ack_after_last", ack, 0);
        @(negedge clk);
        chk("read_30_p0", v0, 600);
        chk("read_30_p1", v1, 600);
        // frame restart on the next sample-0 handshake
        hs_valid = 1'b1; hs_data = '0; hs_angle = 8'd40; hs_last = 1'b0;
        @(negedge clk);
        hs_valid = 1'b0;
        chk("has_next_restart", has_next, 1);
        #1 chk("filling_no_ack", ack, 0);
        write_line(40, 0, 1, 1, 99);
        // async reset at sample 100 while angle 30 is being read
        hs_valid = 1'b1; hs_data = 12'sd100;
        #2 rst = 1'b1;
        #1;
        chk("arst_v0", v0, 0);
        chk("arst_v1", v1, 0);
        chk("arst_angle", fr_angle, 0);
        chk("arst_has_next", has_next, 1);
        chk("arst_ready", hs_ready, 0);
        chk("arst_ack", ack, 0);
        @(negedge clk);
        hs_valid = 1'b0; next_angle = 1'b0; rst = 1'b0;
        #1 chk("ready_after_arst", hs_ready, 1);
        write_line(50, 0, 0, 2, 256);
        next_angle = 1'b1; s0 = 9'sd100; s1 = 9'sd255;
        #1 chk("fresh_ack", ack, 1);
        @(negedge clk);
        next_angle = 1'b0;
        chk("angle_50", fr_angle, 50);
        chk("fresh_has_next", has_next, 1);
        @(negedge clk);
        chk("fresh_s100", v0, 200);
        chk("fresh_s255", v1, 510);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
